// File: rtl/mem_port_arbiter_if.sv
// Bundles the fetch, load/store and memory handshake signals of mem_port_arbiter.
// slave is the arbiter's view of the bundle; master is the view of the core and memory around it.
interface mem_port_arbiter_if;
    logic        if_req_i;
    logic [31:0] if_addr_i;
    logic        if_gnt_o;
    logic        if_rvalid_o;
    logic [31:0] if_rdata_o;
    logic        if_err_o;

    logic        ls_req_i;
    logic        ls_we_i;
    logic [31:0] ls_addr_i;
    logic [1:0]  ls_size_i;
    logic        ls_unsigned_i;
    logic [31:0] ls_wdata_i;
    logic        ls_gnt_o;
    logic        ls_rvalid_o;
    logic [31:0] ls_rdata_o;
    logic        ls_err_o;

    logic        mem_req_o;
    logic        mem_we_o;
    logic [31:0] mem_addr_o;
    logic [3:0]  mem_be_o;
    logic [31:0] mem_wdata_o;
    logic        mem_gnt_i;
    logic        mem_rvalid_i;
    logic [31:0] mem_rdata_i;

    modport slave (
        input  if_req_i, if_addr_i,
        output if_gnt_o, if_rvalid_o, if_rdata_o, if_err_o,
        input  ls_req_i, ls_we_i, ls_addr_i, ls_size_i, ls_unsigned_i, ls_wdata_i,
        output ls_gnt_o, ls_rvalid_o, ls_rdata_o, ls_err_o,
        output mem_req_o, mem_we_o, mem_addr_o, mem_be_o, mem_wdata_o,
        input  mem_gnt_i, mem_rvalid_i, mem_rdata_i
    );

    modport master (
        output if_req_i, if_addr_i,
        input  if_gnt_o, if_rvalid_o, if_rdata_o, if_err_o,
        output ls_req_i, ls_we_i, ls_addr_i, ls_size_i, ls_unsigned_i, ls_wdata_i,
        input  ls_gnt_o, ls_rvalid_o, ls_rdata_o, ls_err_o,
        input  mem_req_o, mem_we_o, mem_addr_o, mem_be_o, mem_wdata_o,
        output mem_gnt_i, mem_rvalid_i, mem_rdata_i
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one 32-bit memory port between fetch and load/store: data priority with bounded
// fetch starvation, one transaction in flight, lane steering and load extension for the LSU.
module mem_port_arbiter #(
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    mem_port_arbiter_if.slave   bus
);
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_REQ  = 2'd1;
    localparam logic [1:0] S_RESP = 2'd2;
    localparam logic [1:0] S_ERR  = 2'd3;

    localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);
    localparam logic       OWN_IF = 1'b0;
    localparam logic       OWN_LS = 1'b1;

    logic [1:0]  state_q,  state_d;
    logic [3:0]  streak_q, streak_d;
    logic        owner_q,  owner_d;
    logic [31:0] addr_q,   addr_d;
    logic        we_q,     we_d;
    logic [1:0]  size_q,   size_d;
    logic        uns_q,    uns_d;
    logic [31:0] wdata_q,  wdata_d;

    logic        pick_ls, pick_if, idle;
    logic        ls_bad, if_bad;
    logic [31:0] shifted, ld_data, rsp_data;
    logic        rsp_valid, rsp_err;
    logic        in_req;
    logic [3:0]  be;
    logic [31:0] wdata_rep;

    always_comb begin
        idle    = (state_q == S_IDLE);
        // Gated by rst_n so grants stay low while reset is held with requests pending.
        pick_ls = rst_n && idle && bus.ls_req_i && !(bus.if_req_i && streak_q == LIMIT);
        pick_if = rst_n && idle && bus.if_req_i && !pick_ls;

        if_bad  = (bus.if_addr_i[1:0] != 2'b00);
        ls_bad  = (bus.ls_size_i == 2'b11)
               || (bus.ls_size_i == 2'b01 && bus.ls_addr_i[0])
               || (bus.ls_size_i == 2'b10 && bus.ls_addr_i[1:0] != 2'b00);

        state_d  = state_q;
        streak_d = streak_q;
        owner_d  = owner_q;
        addr_d   = addr_q;
        we_d     = we_q;
        size_d   = size_q;
        uns_d    = uns_q;
        wdata_d  = wdata_q;

        case (state_q)
            S_IDLE: begin
                if (pick_ls) begin
                    owner_d  = OWN_LS;
                    addr_d   = bus.ls_addr_i;
                    we_d     = bus.ls_we_i;
                    size_d   = bus.ls_size_i;
                    uns_d    = bus.ls_unsigned_i;
                    wdata_d  = bus.ls_wdata_i;
                    state_d  = ls_bad ? S_ERR : S_REQ;
                    if (!bus.if_req_i)       streak_d = '0;
                    else if (streak_q != LIMIT) streak_d = streak_q + 4'd1;
                end else if (pick_if) begin
                    owner_d  = OWN_IF;
                    addr_d   = bus.if_addr_i;
                    we_d     = 1'b0;
                    size_d   = 2'b10;
                    uns_d    = 1'b0;
                    wdata_d  = '0;
                    state_d  = if_bad ? S_ERR : S_REQ;
                    streak_d = '0;
                end
            end
            S_REQ:   if (bus.mem_gnt_i)    state_d = S_RESP;
            S_RESP:  if (bus.mem_rvalid_i) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        shifted = bus.mem_rdata_i >> {addr_q[1:0], 3'b000};
        case (size_q)
            2'b00:   ld_data = uns_q ? {24'h0, shifted[7:0]}  : {{24{shifted[7]}}, shifted[7:0]};
            2'b01:   ld_data = uns_q ? {16'h0, shifted[15:0]} : {{16{shifted[15]}}, shifted[15:0]};
            default: ld_data = shifted;
        endcase

        case (size_q)
            2'b00:   be = 4'b0001 << addr_q[1:0];
            2'b01:   be = 4'b0011 << addr_q[1:0];
            default: be = 4'b1111;
        endcase

        case (size_q)
            2'b00:   wdata_rep = {4{wdata_q[7:0]}};
            2'b01:   wdata_rep = {2{wdata_q[15:0]}};
            default: wdata_rep = wdata_q;
        endcase

        in_req    = (state_q == S_REQ);
        rsp_err   = (state_q == S_ERR);
        rsp_valid = rsp_err || (state_q == S_RESP && bus.mem_rvalid_i);
        rsp_data  = '0;
        if (state_q == S_RESP && bus.mem_rvalid_i && !we_q)
            rsp_data = (owner_q == OWN_LS) ? ld_data : bus.mem_rdata_i;
    end

    always_comb begin
        bus.if_gnt_o    = pick_if;
        bus.ls_gnt_o    = pick_ls;
        bus.if_rvalid_o = rsp_valid && (owner_q == OWN_IF);
        bus.if_err_o    = rsp_err   && (owner_q == OWN_IF);
        bus.if_rdata_o  = (owner_q == OWN_IF) ? rsp_data : '0;
        bus.ls_rvalid_o = rsp_valid && (owner_q == OWN_LS);
        bus.ls_err_o    = rsp_err   && (owner_q == OWN_LS);
        bus.ls_rdata_o  = (owner_q == OWN_LS) ? rsp_data : '0;

        bus.mem_req_o   = in_req;
        bus.mem_we_o    = in_req && we_q;
        bus.mem_addr_o  = in_req ? {addr_q[31:2], 2'b00} : '0;
        bus.mem_be_o    = in_req ? be : '0;
        bus.mem_wdata_o = (in_req && we_q) ? wdata_rep : '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            streak_q <= '0;
            owner_q  <= OWN_IF;
            addr_q   <= '0;
            we_q     <= 1'b0;
            size_q   <= '0;
            uns_q    <= 1'b0;
            wdata_q  <= '0;
        end else begin
            state_q  <= state_d;
            streak_q <= streak_d;
            owner_q  <= owner_d;
            addr_q   <= addr_d;
            we_q     <= we_d;
            size_q   <= size_d;
            uns_q    <= uns_d;
            wdata_q  <= wdata_d;
        end
    end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: hand-computed expectations checked with immediate assertions.
module tb_mem_port_arbiter;
    logic clk = 1'b0;
    logic rst_n;
    int   n_cmp = 0;
    int   n_bad = 0;

    mem_port_arbiter_if bus ();

    mem_port_arbiter #(.STARVE_LIMIT(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, observed=running expected=finished");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_ctl"}, {23'h0, bus.if_gnt_o, bus.if_rvalid_o, bus.if_err_o, bus.ls_gnt_o,
                            bus.ls_rvalid_o, bus.ls_err_o, bus.mem_req_o, bus.mem_we_o, |bus.mem_be_o}, '0);
        chk({tag, "_data"}, bus.if_rdata_o | bus.ls_rdata_o | bus.mem_addr_o | bus.mem_wdata_o, '0);
    endtask

    task automatic ls_set(input logic we, input logic [31:0] addr, input logic [1:0] size,
                          input logic uns, input logic [31:0] wdata);
        bus.ls_req_i      = 1'b1;
        bus.ls_we_i       = we;
        bus.ls_addr_i     = addr;
        bus.ls_size_i     = size;
        bus.ls_unsigned_i = uns;
        bus.ls_wdata_i    = wdata;
    endtask

    initial begin
        rst_n = 1'b0;
        bus.if_req_i = 1'b1; bus.if_addr_i = 32'h0;
        ls_set(1'b0, 32'h0, 2'b00, 1'b0, 32'h0);
        bus.mem_gnt_i = 1'b0; bus.mem_rvalid_i = 1'b0; bus.mem_rdata_i = 32'h0;

        // Reset held for 3 cycles with both requests asserted
        for (int i = 0; i < 3; i++) begin
            step(); #1;
            chk_all_zero("reset");
        end

        // First IDLE: LSU wins (byte load @0), then a sign-extended response
        rst_n = 1'b1; #1;
        chk("rst_ls_gnt", {31'h0, bus.ls_gnt_o}, 32'h1);
        chk("rst_if_gnt", {31'h0, bus.if_gnt_o}, 32'h0);
        step(); bus.ls_req_i = 1'b0; bus.if_req_i = 1'b0; bus.mem_gnt_i = 1'b1; #1;
        chk("rst_mem_req", {31'h0, bus.mem_req_o}, 32'h1);
        chk("rst_mem_be", {28'h0, bus.mem_be_o}, 32'h1);
        step(); bus.mem_gnt_i = 1'b0; bus.mem_rvalid_i = 1'b1; bus.mem_rdata_i = 32'h0000_0085; #1;
        chk("rst_ls_rdata", bus.ls_rdata_o, 32'hFFFF_FF85);
        chk("rst_if_rvalid", {31'h0, bus.if_rvalid_o}, 32'h0);

        // Word fetch
        step(); bus.mem_rvalid_i = 1'b0; bus.if_req_i = 1'b1; bus.if_addr_i = 32'h100; #1;
        chk("fetch_gnt", {31'h0, bus.if_gnt_o}, 32'h1);
        step(); bus.if_req_i = 1'b0; bus.mem_gnt_i = 1'b1; #1;
        chk("fetch_addr", bus.mem_addr_o, 32'h100);
        chk("fetch_be", {28'h0, bus.mem_be_o}, 32'hF);
        chk("fetch_we", {31'h0, bus.mem_we_o}, 32'h0);
        chk("fetch_early_rvalid", {31'h0, bus.if_rvalid_o}, 32'h0);
        step(); bus.mem_gnt_i = 1'b0; bus.mem_rvalid_i = 1'b1; bus.mem_rdata_i = 32'h0050_0093; #1;
        chk("fetch_rvalid", {31'h0, bus.if_rvalid_o}, 32'h1);
        chk("fetch_rdata", bus.if_rdata_o, 32'h0050_0093);
        chk("fetch_err", {31'h0, bus.if_err_o}, 32'h0);
        chk("fetch_ls_rvalid", {31'h0, bus.ls_rvalid_o}, 32'h0);

        // Signed byte load at 0x203; request fields change after grant to prove they were captured
        step(); bus.mem_rvalid_i = 1'b0; ls_set(1'b0, 32'h203, 2'b00, 1'b0, 32'h0); #1;
        chk("lb_gnt", {31'h0, bus.ls_gnt_o}, 32'h1);
        step(); bus.ls_req_i = 1'b0; bus.ls_addr_i = 32'h0; bus.mem_gnt_i = 1'b1; #1;
        chk("lb_addr", bus.mem_addr_o, 32'h200);
        chk("lb_be", {28'h0, bus.mem_be_o}, 32'h8);
        step(); bus.mem_gnt_i = 1'b0; bus.mem_rvalid_i = 1'b1; bus.mem_rdata_i = 32'h80FF_1234; #1;
        chk("lb_rdata", bus.ls_rdata_o, 32'hFFFF_FF80);

        // Unsigned byte load, response delayed one cycle
        step(); bus.mem_rvalid_i = 1'b0; ls_set(1'b0, 32'h203, 2'b00, 1'b1, 32'h0); #1;
        chk("lbu_gnt", {31'h0, bus.ls_gnt_o}, 32'h1);
        step(); bus.ls_req_i = 1'b0; bus.mem_gnt_i = 1'b1; #1;
        step(); bus.mem_gnt_i = 1'b0; #1;
        chk("lbu_wait_rvalid", {31'h0, bus.ls_rvalid_o}, 32'h0);
        step(); bus.mem_rvalid_i = 1'b1; #1;
        chk("lbu_rvalid", {31'h0, bus.ls_rvalid_o}, 32'h1);
        chk("lbu_rdata", bus.ls_rdata_o, 32'h0000_0080);

        // Half store at 0x302; mem_rvalid_i in REQ must be ignored
        step(); bus.mem_rvalid_i = 1'b0; ls_set(1'b1, 32'h302, 2'b01, 1'b0, 32'hDEAD_BEEF); #1;
        chk("sh_gnt", {31'h0, bus.ls_gnt_o}, 32'h1);
        step(); bus.ls_req_i = 1'b0; bus.mem_gnt_i = 1'b1; bus.mem_rvalid_i = 1'b1; #1;
        chk("sh_be", {28'h0, bus.mem_be_o}, 32'hC);
        chk("sh_wdata", bus.mem_wdata_o, 32'hBEEF_BEEF);
        chk("sh_we", {31'h0, bus.mem_we_o}, 32'h1);
        chk("sh_addr", bus.mem_addr_o, 32'h300);
        chk("sh_req_rvalid_ignored", {31'h0, bus.ls_rvalid_o}, 32'h0);
        step(); bus.mem_gnt_i = 1'b0; bus.mem_rdata_i = 32'hFFFF_FFFF; #1;
        chk("sh_rvalid", {31'h0, bus.ls_rvalid_o}, 32'h1);
        chk("sh_rdata", bus.ls_rdata_o, 32'h0);

        // Misaligned word load, invalid size, misaligned fetch
        step(); bus.mem_rvalid_i = 1'b0; ls_set(1'b0, 32'h401, 2'b10, 1'b0, 32'h0); #1;
        chk("mis_gnt", {31'h0, bus.ls_gnt_o}, 32'h1);
        chk("mis_mem_req0", {31'h0, bus.mem_req_o}, 32'h0);
        step(); bus.ls_req_i = 1'b0; #1;
        chk("mis_rv_err", {30'h0, bus.ls_rvalid_o, bus.ls_err_o}, 32'h3);
        chk("mis_rdata", bus.ls_rdata_o, 32'h0);
        chk("mis_mem_req1", {31'h0, bus.mem_req_o}, 32'h0);
        step(); ls_set(1'b0, 32'h400, 2'b11, 1'b0, 32'h0); #1;
        chk("inv_gnt", {31'h0, bus.ls_gnt_o}, 32'h1);
        step(); bus.ls_req_i = 1'b0; #1;
        chk("inv_rv_err", {30'h0, bus.ls_rvalid_o, bus.ls_err_o}, 32'h3);
        chk("inv_mem_req", {31'h0, bus.mem_req_o}, 32'h0);
        step(); bus.if_req_i = 1'b1; bus.if_addr_i = 32'h102; #1;
        chk("ifmis_gnt", {31'h0, bus.if_gnt_o}, 32'h1);
        step(); bus.if_req_i = 1'b0; #1;
        chk("ifmis_rv_err", {30'h0, bus.if_rvalid_o, bus.if_err_o}, 32'h3);
        chk("ifmis_ls_rvalid", {31'h0, bus.ls_rvalid_o}, 32'h0);

        // Starvation bound: both requesting, memory grants and responds at once
        step();
        bus.if_req_i = 1'b1; bus.if_addr_i = 32'h104;
        ls_set(1'b0, 32'h500, 2'b10, 1'b0, 32'h0);
        bus.mem_gnt_i = 1'b1; bus.mem_rvalid_i = 1'b1; bus.mem_rdata_i = 32'h1234_5678; #1;
        for (int k = 0; k < 10; k++) begin
            chk($sformatf("starve_gnt%0d", k), {30'h0, bus.if_gnt_o, bus.ls_gnt_o},
                (k % 5 == 4) ? 32'h2 : 32'h1);
            step(); #1;
            step(); #1;
            step(); #1;
        end

        // Stalled memory grant: request and fields stay put, other requester waits
        chk("stall_gnt", {30'h0, bus.if_gnt_o, bus.ls_gnt_o}, 32'h1);
        bus.mem_gnt_i = 1'b0;
        for (int c = 0; c < 5; c++) begin
            step(); #1;
            chk($sformatf("stall_req%0d", c), {31'h0, bus.mem_req_o}, 32'h1);
            chk($sformatf("stall_addr%0d", c), bus.mem_addr_o, 32'h500);
            chk($sformatf("stall_be%0d", c), {28'h0, bus.mem_be_o}, 32'hF);
            chk($sformatf("stall_if_gnt%0d", c), {31'h0, bus.if_gnt_o}, 32'h0);
        end
        step(); bus.mem_gnt_i = 1'b1; #1;
        step(); bus.mem_gnt_i = 1'b0; bus.if_req_i = 1'b0; bus.ls_req_i = 1'b0; #1;
        chk("stall_rvalid", {31'h0, bus.ls_rvalid_o}, 32'h1);
        chk("stall_rdata", bus.ls_rdata_o, 32'h1234_5678);

        // Reset in the middle of a fetch abandons it
        step(); bus.mem_rvalid_i = 1'b0; bus.if_req_i = 1'b1; bus.if_addr_i = 32'h200; #1;
        chk("abort_gnt", {31'h0, bus.if_gnt_o}, 32'h1);
        step(); bus.if_req_i = 1'b0; #1;
        chk("abort_req", {31'h0, bus.mem_req_o}, 32'h1);
        rst_n = 1'b0; #1;
        chk_all_zero("abort_rst");
        step(); rst_n = 1'b1; bus.mem_rvalid_i = 1'b1; #1;
        chk_all_zero("abort_idle");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the core's single 32-bit memory port between the instruction-fetch requester and the load/store requester.
- Load/store requests carry the decoder's mem_read/mem_write, mem_size and mem_unsigned.
- The block arbitrates with data priority and bounded fetch starvation, then sequences one transaction at a time (request, grant, response).
- For the load/store path it generates byte enables, replicates store data, aligns and extends load data, and flags misaligned or invalid accesses without touching memory.

Parameters:
STARVE_LIMIT, 4, max consecutive LSU grants while fetch is waiting; the next grant goes to fetch (1..15).

Ports:
clk  in  1  core clock, rising edge
rst_n  in  1  asynchronous active-low reset
if_req_i  in  1  fetch request; address held stable until if_gnt_o
if_addr_i  in  32  fetch byte address
if_gnt_o  out  1  fetch request accepted (1-cycle pulse)
if_rvalid_o  out  1  fetch response valid (1-cycle pulse)
if_rdata_o  out  32  fetched instruction word
if_err_o  out  1  fetch error, qualified by if_rvalid_o
ls_req_i  in  1  load/store request; fields held stable until ls_gnt_o
ls_we_i  in  1  1 = store (mem_write), 0 = load (mem_read)
ls_addr_i  in  32  data byte address
ls_size_i  in  2  00 = byte, 01 = half, 10 = word, 11 = invalid
ls_unsigned_i  in  1  zero-extend load result
ls_wdata_i  in  32  store data, right-justified
ls_gnt_o  out  1  LSU request accepted (1-cycle pulse)
ls_rvalid_o  out  1  LSU response valid (1-cycle pulse)
ls_rdata_o  out  32  aligned and extended load data; 0 for stores
ls_err_o  out  1  LSU error, qualified by ls_rvalid_o
mem_req_o  out  1  memory request, held until mem_gnt_i
mem_we_o  out  1  memory write
mem_addr_o  out  32  word address: {addr[31:2], 2'b00}
mem_be_o  out  4  byte enables
mem_wdata_o  out  32  lane-replicated write data
mem_gnt_i  in  1  memory accepted request this cycle
mem_rvalid_i  in  1  memory response, at least 1 cycle after mem_gnt_i
mem_rdata_i  in  32  memory read word

Behaviour:
- Reset (async on rst_n low):
  - FSM goes to IDLE, streak counter to 0, owner register to fetch.
  - All outputs are 0 while reset is asserted and in the first IDLE cycle with no requests.
- FSM states: IDLE, REQ, RESP, ERR. At most one transaction is outstanding.
- IDLE arbitration:
  - Combinational pick. ls wins if ls_req_i and not (if_req_i and streak == STARVE_LIMIT); otherwise if wins if if_req_i.
  - The winner's gnt_o is asserted in the same cycle; its fields are registered (addr, we, size, unsigned, wdata, owner).
  - Next state is ERR if the request is misaligned, otherwise REQ.
- Streak counter:
  - Increments on an LSU grant while if_req_i = 1.
  - Clears on a fetch grant, or on an LSU grant with if_req_i = 0.
  - Saturates at STARVE_LIMIT.
- Misaligned / invalid request conditions:
  - Fetch with addr[1:0] != 0.
  - LSU half with addr[0] = 1.
  - LSU word with addr[1:0] != 0.
  - LSU size = 11.
- REQ: mem_req_o = 1 with registered fields, held stable until mem_gnt_i. When mem_gnt_i = 1, go to RESP. mem_rvalid_i is ignored in REQ.
- RESP: wait for mem_rvalid_i. In that same cycle, the owner's rvalid_o = 1 (combinational), err_o = 0, rdata driven; next state IDLE. mem_rvalid_i is ignored in any state other than RESP.
- ERR: for one cycle the owner's rvalid_o = 1, err_o = 1, rdata = 0; next state IDLE. No memory request is issued.
- Best-case latency: gnt in cycle 0, mem_req_o in cycle 1, response 1 cycle after mem_gnt_i. Minimum is 3 cycles per access.
- Byte enables (off = addr[1:0]):
  - byte: 4'b0001 << off
  - half: 4'b0011 << off
  - word: 4'b1111
  - fetch: 4'b1111, we = 0
- Store data replication:
  - byte: {4{wdata[7:0]}}
  - half: {2{wdata[15:0]}}
  - word: passthrough
- Load data:
  - Shift mem_rdata_i right by 8*off.
  - Then sign-extend from bit 7 (byte) or bit 15 (half), or zero-extend if unsigned. Word is passthrough.
  - Store responses return rdata = 0.
- Non-owner rvalid/err/rdata outputs stay 0. mem_* outputs are 0 in IDLE and ERR.
- Requests arriving outside IDLE wait; the requester keeps req asserted.
- Reset mid-transaction abandons it: no response is issued and the memory side is reset with the core.

Test Plan:
- Reset:
  - Stimulus: rst_n low for 3 cycles with ls_req_i = if_req_i = 1.
  - Required: all outputs 0. After release, ls_gnt_o pulses in the first IDLE cycle.
- Word fetch:
  - Stimulus: if_addr_i = 0x100; mem_gnt_i on the first REQ cycle; mem_rvalid_i next cycle with 0x00500093.
  - Required: mem_addr_o = 0x100, mem_be_o = 0xF. if_rvalid_o = 1 with if_rdata_o = 0x00500093. Exactly 3 cycles from gnt to rvalid.
- Byte load, sign and zero extension:
  - Stimulus: ls_addr_i = 0x203, size 00, mem_rdata_i = 0x80FF_1234.
  - Required: mem_addr_o = 0x200, be = 0x8. ls_rdata_o = 0xFFFF_FF80 when signed, 0x0000_0080 when unsigned.
- Half store:
  - Stimulus: ls_addr_i = 0x302, ls_wdata_i = 0xDEAD_BEEF, size 01.
  - Required: mem_be_o = 0xC, mem_wdata_o = 0xBEEF_BEEF, mem_we_o = 1. ls_rdata_o = 0 on response.
- Misaligned and invalid:
  - Stimulus: word load at 0x401, then size 11 at 0x400.
  - Required: each gets ls_gnt_o, then ls_rvalid_o = ls_err_o = 1 the next cycle. mem_req_o never asserts.
- Starvation bound:
  - Stimulus: if_req_i and ls_req_i held high continuously, STARVE_LIMIT = 4, memory grants and responds immediately.
  - Required: grant pattern is 4 LSU, 1 fetch, repeating. mem_gnt_i delayed 5 cycles keeps mem_req_o and fields stable.
